// File: rtl/phy_pkg.sv
// Shared PCIe lane-level symbols and RX alignment state encoding.
package phy_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_to_parallel_rx.sv
// Bit-rate serial-to-byte converter: COM alignment, sticky lock, byte output for demux1x4.
module serial_to_parallel_rx
    import phy_pkg::*;
#(
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    rx_state_t  state_q, state_d;
    // Only the 7 most recent bits are needed; nxt appends the live data_in bit.
    logic [6:0] shreg_q;
    logic [7:0] nxt;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [3:0] com_cnt_inc;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;
    logic       boundary;

    assign nxt         = {shreg_q, data_in};
    assign boundary    = (bit_cnt_q == 3'd7);
    assign com_cnt_inc = com_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;

        unique case (state_q)
            SEARCH: begin
                if (nxt == COM) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (COM_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (nxt == COM) begin
                        if (com_cnt_inc >= 4'(COM_COUNT)) begin
                            com_cnt_d = 4'(COM_COUNT);
                            state_d   = ACTIVE;
                            active_d  = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_inc;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d   = nxt;
                    valid_d  = (nxt != COM) && (nxt != IDL);
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= nxt[6:0];
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: alignment, lock loss, byte output, reset.
module tb_serial_to_parallel_rx;
    import phy_pkg::*;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out, data_out1;
    logic       valid_out, valid_out1;
    logic       byte_strobe, byte_strobe1;
    logic       active, active1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk32f = ~clk32f;

    serial_to_parallel_rx #(.COM_COUNT(4)) dut (
        .clk32f     (clk32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    serial_to_parallel_rx #(.COM_COUNT(1)) dut1 (
        .clk32f     (clk32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out1),
        .valid_out  (valid_out1),
        .byte_strobe(byte_strobe1),
        .active     (active1)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk32f);
        data_in = b;
        @(posedge clk32f);
        #1;
    endtask

    // Sends one byte MSB first; reports strobes seen, last strobe bit position,
    // and whether dut outputs held steady until the final bit.
    task automatic send_byte(input logic [7:0] b, output int nstrobe, output int spos,
                             output bit held);
        logic [7:0] d0;
        logic       v0;
        d0      = data_out;
        v0      = valid_out;
        nstrobe = 0;
        spos    = -1;
        held    = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (byte_strobe) begin
                nstrobe++;
                spos = 7 - i;
            end
            if (i != 0 && (data_out !== d0 || valid_out !== v0)) held = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk32f);
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (3) @(negedge clk32f);
        reset = 1'b1;
    endtask

    initial begin
        int  ns, sp;
        bit  hd;

        vecs[0] = '{din: 8'hBC, exp_data: 8'hBC, exp_valid: 1'b0};
        vecs[1] = '{din: 8'h7C, exp_data: 8'h7C, exp_valid: 1'b0};
        vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_valid: 1'b1};
        vecs[3] = '{din: 8'h00, exp_data: 8'h00, exp_valid: 1'b1};
        vecs[4] = '{din: 8'h01, exp_data: 8'h01, exp_valid: 1'b1};

        // Reset state
        do_reset();
        #1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_strobe", 32'(byte_strobe), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(SEARCH));

        // 3 leading bits, 4 COMs, then A5
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC, ns, sp, hd);
            check($sformatf("align_active_%0d", k), 32'(active), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("align_nostrobe_%0d", k), 32'(ns), 32'd0);
        end
        send_byte(8'hA5, ns, sp, hd);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_valid", 32'(valid_out), 32'd1);
        check("a5_nstrobe", 32'(ns), 32'd1);
        check("a5_strobe_pos", 32'(sp), 32'd7);

        // Broken alignment run, then realign
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC, ns, sp, hd);
        check("pre_break_state", 32'(dut.state_q), 32'(ALIGN));
        send_byte(8'h11, ns, sp, hd);
        check("break_active", 32'(active), 32'd0);
        check("break_state", 32'(dut.state_q), 32'(SEARCH));
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC, ns, sp, hd);
            check($sformatf("realign_active_%0d", k), 32'(active), (k == 3) ? 32'd1 : 32'd0);
        end
        send_byte(8'h3C, ns, sp, hd);
        check("3c_data", 32'(data_out), 32'h3C);
        check("3c_valid", 32'(valid_out), 32'd1);
        check("3c_nstrobe", 32'(ns), 32'd1);

        // Table-driven byte stream while ACTIVE
        for (int k = 0; k < 5; k++) begin
            send_byte(vecs[k].din, ns, sp, hd);
            check($sformatf("vec%0d_data", k), 32'(data_out), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d_valid", k), 32'(valid_out), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_nstrobe", k), 32'(ns), 32'd1);
            check($sformatf("vec%0d_strobe_pos", k), 32'(sp), 32'd7);
            check($sformatf("vec%0d_held", k), 32'(hd), 32'd1);
        end

        // Asynchronous reset mid-byte discards partial byte
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk32f);
        reset = 1'b0;
        #1;
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_data", 32'(data_out), 32'h00);
        check("async_rst_valid", 32'(valid_out), 32'd0);
        check("async_rst_state", 32'(dut.state_q), 32'(SEARCH));
        repeat (3) @(negedge clk32f);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_byte(8'h00, ns, sp, hd);
        check("post_rst_active", 32'(active), 32'd0);
        check("post_rst_nstrobe", 32'(ns), 32'd0);
        check("post_rst_data", 32'(data_out), 32'h00);

        // COM_COUNT=1 instance locks on the first COM
        do_reset();
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_byte(8'hBC, ns, sp, hd);
        check("cc1_active", 32'(active1), 32'd1);
        check("cc4_not_active", 32'(active), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(sp >= -1 ? 1'(8'h55 >> i) : 1'b0);
            if (i != 0) check($sformatf("cc1_nostrobe_b%0d", i), 32'(byte_strobe1), 32'd0);
        end
        check("cc1_data", 32'(data_out1), 32'h55);
        check("cc1_valid", 32'(valid_out1), 32'd1);
        check("cc1_strobe", 32'(byte_strobe1), 32'd1);
        send_bit(1'b0);
        check("cc1_strobe_pulse", 32'(byte_strobe1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
